commit_stage: RTL

Final pipeline stage, directly downstream of `exe_stage`. It retires the pipe-6 result into the integer register file and owns the machine-mode CSR file: the CSR read port used by issue, `csr_wb` writeback, and the `mcycle`/`minstret` counters. It also owns the trap/return state machine, which turns `exception_pending` or `mret` into a pipeline flush and a PC redirect.

---
 rtl/commit_stage_if.sv | 37 +++
 rtl/commit_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/commit_stage_if.sv
// Pipe-6 retire, CSR and trap/redirect signals between exe_stage, issue and commit_stage.
interface commit_stage_if;
    logic [31:0] wb_data6;
    logic        we6;
    logic [4:0]  rd6;
    logic        instr_valid6;
    logic        csr_we6;
    logic [31:0] csr_wb;
    logic [11:0] csr_wb_addr;
    logic        exception_pending;
    logic [31:0] m_cause;
    logic [31:0] pc_exc;
    logic        mret6;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic        trap_redirect;
    logic [31:0] trap_target;
    logic        commit_busy;

    modport slave (
        input  wb_data6, we6, rd6, instr_valid6, csr_we6, csr_wb, csr_wb_addr,
               exception_pending, m_cause, pc_exc, mret6, csr_raddr,
        output csr_rdata, rf_we, rf_waddr, rf_wdata, flush, trap_redirect,
               trap_target, commit_busy
    );

    modport master (
        output wb_data6, we6, rd6, instr_valid6, csr_we6, csr_wb, csr_wb_addr,
               exception_pending, m_cause, pc_exc, mret6, csr_raddr,
        input  csr_rdata, rf_we, rf_waddr, rf_wdata, flush, trap_redirect,
               trap_target, commit_busy
    );
endinterface

// File: rtl/commit_stage.sv
// Final pipeline stage: register-file retire, machine-mode CSR file, cycle/instret
// counters and the trap/MRET flush-and-redirect state machine.
module commit_stage #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input logic           clk,
    input logic           nrst,
    commit_stage_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, RET = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        mie, mpie;
    logic [31:0] mtvec, mscratch, mepc, mcause;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic        idle, ok, csr_wr;
    logic        flush_c, redirect_c;
    logic [31:0] target_c, rdata_c;

    assign idle   = (state_q == IDLE);
    assign ok     = idle && !bus.exception_pending && !bus.mret6;
    assign csr_wr = bus.csr_we6 && ok;

    assign bus.rf_we    = bus.we6 && ok && (bus.rd6 != 5'd0);
    assign bus.rf_waddr = bus.rd6;
    assign bus.rf_wdata = bus.wb_data6;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        flush_c    = 1'b0;
        redirect_c = 1'b0;
        target_c   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.exception_pending) begin
                    flush_c = 1'b1;
                    state_d = TRAP;
                end else if (bus.mret6) begin
                    flush_c = 1'b1;
                    state_d = RET;
                end
            end
            TRAP: begin
                flush_c    = 1'b1;
                redirect_c = 1'b1;
                target_c   = mtvec;
                state_d    = IDLE;
            end
            RET: begin
                flush_c    = 1'b1;
                redirect_c = 1'b1;
                target_c   = mepc;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.flush         = flush_c;
    assign bus.trap_redirect = redirect_c;
    assign bus.trap_target   = target_c;
    assign bus.commit_busy   = !idle;

    // Trap entry beats MRET, which beats an ordinary CSR write in the same slot.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (idle && bus.exception_pending) begin
            mepc   <= bus.pc_exc;
            mcause <= bus.m_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (idle && bus.mret6) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (csr_wr) begin
            case (bus.csr_wb_addr)
                A_MSTATUS: begin
                    mie  <= bus.csr_wb[3];
                    mpie <= bus.csr_wb[7];
                end
                A_MTVEC:    mtvec    <= bus.csr_wb;
                A_MSCRATCH: mscratch <= bus.csr_wb;
                A_MEPC:     mepc     <= bus.csr_wb;
                A_MCAUSE:   mcause   <= bus.csr_wb;
                default: ;
            endcase
        end
    end

    // A write to either counter half replaces it and suppresses that cycle's increment.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.instr_valid6 && ok};
        if (csr_wr) begin
            case (bus.csr_wb_addr)
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], bus.csr_wb};
                A_MCYCLEH:   mcycle_d   = {bus.csr_wb, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], bus.csr_wb};
                A_MINSTRETH: minstret_d = {bus.csr_wb, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    always_comb begin
        rdata_c = '0;
        case (bus.csr_raddr)
            A_MSTATUS:   rdata_c = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
            A_MTVEC:     rdata_c = mtvec;
            A_MSCRATCH:  rdata_c = mscratch;
            A_MEPC:      rdata_c = mepc;
            A_MCAUSE:    rdata_c = mcause;
            A_MCYCLE:    rdata_c = mcycle_q[31:0];
            A_MCYCLEH:   rdata_c = mcycle_q[63:32];
            A_MINSTRET:  rdata_c = minstret_q[31:0];
            A_MINSTRETH: rdata_c = minstret_q[63:32];
            default:     rdata_c = '0;
        endcase
    end

    assign bus.csr_rdata = rdata_c;
endmodule
